// File: rtl/tick_chk_pkg.sv
// Shared types and default constants for the tick period checker.
package tick_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } tick_chk_state_t;

    localparam int unsigned DEF_PERIOD = 15001;
    localparam int unsigned DEF_CBITS  = 15;

endpackage

// File: rtl/tick_period_checker_if.sv
// Tick input and status outputs of the tick period checker.
interface tick_period_checker_if #(
    parameter int unsigned EBITS = 8
);
    logic             tick;
    logic             locked;
    logic             early;
    logic             late;
    logic             fault;
    logic [EBITS-1:0] err_cnt;

    modport master (output tick, input locked, early, late, fault, err_cnt);
    modport slave  (input tick, output locked, early, late, fault, err_cnt);
endinterface

// File: rtl/tick_gap_counter.sv
// Edges since the last tick: loads 1 on a tick, otherwise saturating increment.
module tick_gap_counter
    import tick_chk_pkg::*;
#(
    parameter int unsigned CBITS = DEF_CBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    output logic [CBITS-1:0] gap
);

    always_ff @(posedge clk) begin
        if (rst) begin
            gap <= '0;
        end else if (load) begin
            gap <= CBITS'(1);
        end else if (gap != {CBITS{1'b1}}) begin
            gap <= gap + CBITS'(1);
        end
    end

endmodule

// File: rtl/tick_period_checker.sv
// Measures tick spacing, locks after a run of good intervals, flags early/late ticks.
module tick_period_checker
    import tick_chk_pkg::*;
#(
    parameter int unsigned PERIOD   = DEF_PERIOD,
    parameter int unsigned TOL      = 0,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned CBITS    = DEF_CBITS,
    parameter int unsigned EBITS    = 8
) (
    input logic                 clk,
    input logic                 rst,
    tick_period_checker_if.slave bus
);

    localparam int unsigned     SBITS       = $clog2(LOCK_CNT + 1);
    localparam logic [CBITS-1:0] GAP_LO     = CBITS'(PERIOD - TOL);
    localparam logic [CBITS-1:0] GAP_HI     = CBITS'(PERIOD + TOL);
    localparam logic [SBITS-1:0] STREAK_END = SBITS'(LOCK_CNT);
    localparam logic [EBITS-1:0] ERR_MAX    = {EBITS{1'b1}};

    logic [CBITS-1:0] gap;
    logic             is_early;
    logic             is_good;
    logic             is_late;

    tick_chk_state_t  state, state_d;
    logic [SBITS-1:0] streak, streak_d;
    logic             locked_q, early_q, late_q, fault_q;
    logic             early_d, late_d, fault_d;
    logic [EBITS-1:0] err_q, err_d;

    tick_gap_counter #(.CBITS(CBITS)) u_gap (
        .clk  (clk),
        .rst  (rst),
        .load (bus.tick),
        .gap  (gap)
    );

    // Pre-edge gap on a tick edge is the interval just completed.
    assign is_early = bus.tick && (gap < GAP_LO);
    assign is_good  = bus.tick && (gap >= GAP_LO) && (gap <= GAP_HI);
    assign is_late  = !bus.tick && (gap == GAP_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            streak   <= '0;
            locked_q <= 1'b0;
            early_q  <= 1'b0;
            late_q   <= 1'b0;
            fault_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            state    <= state_d;
            streak   <= streak_d;
            locked_q <= (state_d == LOCKED);
            early_q  <= early_d;
            late_q   <= late_d;
            fault_q  <= fault_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state;
        streak_d = streak;
        case (state)
            IDLE: begin
                if (bus.tick) begin
                    state_d  = ACQ;
                    streak_d = '0;
                end
            end
            ACQ: begin
                if (is_good) begin
                    if (streak + SBITS'(1) == STREAK_END) begin
                        state_d  = LOCKED;
                        streak_d = '0;
                    end else begin
                        streak_d = streak + SBITS'(1);
                    end
                end else if (is_late) begin
                    state_d  = IDLE;
                    streak_d = '0;
                end else if (bus.tick) begin
                    streak_d = '0;
                end
            end
            LOCKED: begin
                if (is_early) begin
                    state_d  = ACQ;
                    streak_d = '0;
                end else if (is_late) begin
                    state_d  = IDLE;
                    streak_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                streak_d = '0;
            end
        endcase
    end

    // IDLE never raises early/late; only faults seen while locked are sticky.
    always_comb begin
        early_d = (state != IDLE) && is_early;
        late_d  = (state != IDLE) && is_late;
        fault_d = fault_q || ((state == LOCKED) && (is_early || is_late));
        err_d   = err_q;
        if ((early_d || late_d) && (err_q != ERR_MAX)) begin
            err_d = err_q + EBITS'(1);
        end
    end

    assign bus.locked  = locked_q;
    assign bus.early   = early_q;
    assign bus.late    = late_q;
    assign bus.fault   = fault_q;
    assign bus.err_cnt = err_q;

endmodule
